spart_echo_driver: RTL and testbench

Parametrised processor-side driver for the SPART UART.
- Programs the baud divisor from a clock-frequency parameter and `br_cfg`.
- Moves received bytes into an internal FIFO and echoes them back out of the transmitter.
- Decouples RX and TX so bursts up to FIFO_DEPTH bytes are not lost while TX is busy.
- Sits between top-level switches and the SPART bus interface.

---
 rtl/spart_echo_driver.sv | 272 +++++++++++++++++++++++++++
 tb/tb_spart_echo_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_echo_driver.sv
// SPART echo driver: programs the baud divisor, then moves received bytes through an echo FIFO back to the transmitter.
// Latency: a byte read in an RD cycle is driven in a WR cycle no earlier than two cycles later (RD, IDLE, WR).
// Backpressure: a full FIFO leaves rda pending in the SPART; an empty FIFO or a low tbr holds off WR.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   br_cfg          baud select 00=4800 01=9600 10=19200 11=38400
//   rda, tbr        SPART receive-data-available / transmit-buffer-ready
//   iocs, iorw      SPART chip select (bus cycles only) and direction (1=read)
//   ioaddr          00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high
//   databus         bidirectional; driven only for divisor and TX writes
//   fifo_count      echo FIFO occupancy
//   cfg_done        divisor programmed for the current br_cfg
//
// Build option: define SPART_DRV_UPCASE_EN to fold ASCII 'a'..'z' to upper case
// before the byte enters the FIFO. Without it bytes are echoed verbatim.

// Echo FIFO: single-clock circular buffer with occupancy count.
// Latency: push visible at head/count on the next cycle.
// Backpressure: caller must not push when full or pop when empty.
module spart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_dat_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
endmodule

module spart_echo_driver #(
    parameter int CLK_HZ     = 50000000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [DATA_W-1:0]             databus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cfg_done
);
    typedef enum logic [2:0] {
        DB_LO,
        DB_HI,
        IDLE,
        RD,
        WR
    } state_t;

    // Divisor = CLK_HZ / (16 * baud) - 1, fixed at elaboration.
    localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_HZ / (16 * 4800)  - 1);
    localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_HZ / (16 * 9600)  - 1);
    localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_HZ / (16 * 19200) - 1);
    localparam logic [DIV_W-1:0] DIV_38400 = DIV_W'(CLK_HZ / (16 * 38400) - 1);

    function automatic logic [DIV_W-1:0] div_for(input logic [1:0] cfg);
        logic [DIV_W-1:0] d;
        case (cfg)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return d;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          cfg_q;        // br_cfg the SPART is programmed with
    logic [1:0]          pend_q;       // br_cfg being programmed (both bytes use it)
    logic                cfg_done_q;
    logic                last_rx_q;    // last serviced access was a read
    logic                iocs_q;
    logic                iorw_q;
    logic [1:0]          ioaddr_q;
    logic                drive_q;
    logic [DATA_W-1:0]   dout_q;

    logic [DIV_W-1:0]    div_new;
    logic [DIV_W-1:0]    div_pend;
    logic [DATA_W-1:0]   push_dat;
    logic [DATA_W-1:0]   head_dat;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rx_ok;
    logic                tx_ok;

    assign div_new  = div_for(br_cfg);
    assign div_pend = div_for(pend_q);

`ifdef SPART_DRV_UPCASE_EN
    // Fold 'a'..'z' onto 'A'..'Z'; every other byte passes through.
    always_comb begin
        push_dat = databus;
        if ((databus >= DATA_W'(8'h61)) && (databus <= DATA_W'(8'h7A))) begin
            push_dat = databus - DATA_W'(8'h20);
        end
    end
`else
    assign push_dat = databus;
`endif

    // Push/pop happen at the edge that ends the one-cycle RD/WR access,
    // which also makes them mutually exclusive.
    assign fifo_push = (state_q == RD);
    assign fifo_pop  = (state_q == WR);

    spart_echo_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign tx_ok = tbr && !fifo_empty;
    // A read is taken unless a write is also possible and the last access
    // was already a read; this alternates service when both sides are busy.
    assign rx_ok = rda && !fifo_full && (!tx_ok || !last_rx_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Out of reset the bus is idle while parked in DB_LO, so the
            // first edge only launches the low-byte write; iocs_q tells the
            // two cases apart.
            DB_LO: state_d = iocs_q ? DB_HI : DB_LO;
            DB_HI: state_d = IDLE;
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    state_d = DB_LO;
                end else if (rx_ok) begin
                    state_d = RD;
                end else if (tx_ok) begin
                    state_d = WR;
                end
            end
            RD:      state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = DB_LO;
        endcase
    end

    // Bus outputs are registered from state_d so they line up with state_q
    // for the cycle that follows the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DB_LO;
            cfg_q      <= 2'b00;
            pend_q     <= 2'b00;
            cfg_done_q <= 1'b0;
            last_rx_q  <= 1'b0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b00;
            drive_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q  <= state_d;
            iocs_q   <= (state_d != IDLE);
            iorw_q   <= !((state_d == DB_LO) || (state_d == DB_HI) || (state_d == WR));
            drive_q  <= (state_d == DB_LO) || (state_d == DB_HI) || (state_d == WR);
            ioaddr_q <= 2'b00;

            case (state_d)
                DB_LO: begin
                    ioaddr_q <= 2'b10;
                    if (state_q != DB_LO || !iocs_q) begin
                        pend_q <= br_cfg;
                        dout_q <= DATA_W'(div_new);
                    end
                end
                DB_HI: begin
                    ioaddr_q <= 2'b11;
                    dout_q   <= DATA_W'(div_pend >> DATA_W);
                end
                WR: begin
                    dout_q <= head_dat;
                end
                default: begin
                end
            endcase

            if (state_q == DB_HI) begin
                cfg_q      <= pend_q;
                cfg_done_q <= 1'b1;
            end else if ((state_q == IDLE) && (state_d == DB_LO)) begin
                cfg_done_q <= 1'b0;
            end

            if (state_q == RD) begin
                last_rx_q <= 1'b1;
            end else if (state_q == WR) begin
                last_rx_q <= 1'b0;
            end
        end
    end

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign cfg_done = cfg_done_q;
    assign databus  = drive_q ? dout_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_spart_echo_driver.sv
// Directed bench for spart_echo_driver with a small SPART bus model.
// Latency: checks exact cycle placement of divisor writes and RD/IDLE/WR echo.
// Backpressure: exercises a full FIFO with rda pending and tbr-gated draining.
module tb_spart_echo_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       tbr;
    logic       rda;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [3:0] fifo_count;
    logic       cfg_done;

    int n_vec = 0;
    int n_bad = 0;

    // SPART receive side: bytes queued by the stimulus, offered on reads.
    logic [7:0] rx_mem [0:31];
    logic [4:0] rx_rd = 5'd0;
    logic [4:0] rx_wr = 5'd0;
    logic [7:0] rx_dat;

    // SPART transmit side: every TX write captured in order.
    logic [7:0] tx_log [0:63];
    int tx_cnt = 0;

    always #5 clk = ~clk;

    assign rda     = (rx_rd != rx_wr);
    assign rx_dat  = rx_mem[rx_rd];
    assign databus = (iocs && iorw) ? rx_dat : 8'hzz;

    always @(posedge clk) begin
        if (iocs && iorw && (ioaddr == 2'b00) && (rx_rd != rx_wr)) begin
            rx_rd <= rx_rd + 5'd1;
        end
    end

    always @(negedge clk) begin
        if (iocs && !iorw && (ioaddr == 2'b00)) begin
            tx_log[tx_cnt] = databus;
            tx_cnt = tx_cnt + 1;
        end
    end

    spart_echo_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .fifo_count (fifo_count),
        .cfg_done   (cfg_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 5'd1;
    endtask

    task automatic wait_count(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && fifo_count != target[3:0]; i++) step();
        check_eq(tag, {28'd0, fifo_count}, target);
    endtask

    task automatic wait_tx(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && tx_cnt < target; i++) step();
        check_eq(tag, tx_cnt, target);
    endtask

    // Divisor low/high write cycles for the configuration just released.
    task automatic check_div(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        step();
        check_eq({tag, "_lo_addr"}, {30'd0, ioaddr}, 32'h2);
        check_eq({tag, "_lo_rw"}, {31'd0, iorw}, 32'h0);
        check_eq({tag, "_lo_dat"}, {24'd0, databus}, {24'd0, lo});
        step();
        check_eq({tag, "_hi_addr"}, {30'd0, ioaddr}, 32'h3);
        check_eq({tag, "_hi_dat"}, {24'd0, databus}, {24'd0, hi});
        step();
        check_eq({tag, "_done"}, {31'd0, cfg_done}, 32'h1);
        check_eq({tag, "_idle"}, {31'd0, iocs}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] up_exp [0:3];

        rst    = 1'b1;
        br_cfg = 2'b01;
        tbr    = 1'b0;
        repeat (3) step();
        check_eq("rst_iocs", {31'd0, iocs}, 32'h0);
        check_eq("rst_iorw", {31'd0, iorw}, 32'h1);
        check_eq("rst_ioaddr", {30'd0, ioaddr}, 32'h0);
        check_eq("rst_count", {28'd0, fifo_count}, 32'h0);
        check_eq("rst_cfg_done", {31'd0, cfg_done}, 32'h0);
        rst = 1'b0;
        // 50 MHz: 9600 -> 324 = 0x0144
        check_div("div9600", 8'h44, 8'h01);

        // 4800 -> 650 = 0x028A
        rst = 1'b1; br_cfg = 2'b00; step(); rst = 1'b0;
        check_div("div4800", 8'h8A, 8'h02);

        // 38400 -> 80 = 0x0050
        rst = 1'b1; br_cfg = 2'b11; step(); rst = 1'b0;
        check_div("div38400", 8'h50, 8'h00);

        // Single echo: RD, IDLE, WR, IDLE
        tbr = 1'b1;
        push_rx(8'h41);
        step();
        check_eq("echo_rd_cs", {31'd0, iocs}, 32'h1);
        check_eq("echo_rd_rw", {31'd0, iorw}, 32'h1);
        check_eq("echo_rd_addr", {30'd0, ioaddr}, 32'h0);
        step();
        check_eq("echo_cnt1", {28'd0, fifo_count}, 32'h1);
        check_eq("echo_gap_cs", {31'd0, iocs}, 32'h0);
        step();
        check_eq("echo_wr_cs", {31'd0, iocs}, 32'h1);
        check_eq("echo_wr_rw", {31'd0, iorw}, 32'h0);
        check_eq("echo_wr_addr", {30'd0, ioaddr}, 32'h0);
        check_eq("echo_wr_dat", {24'd0, databus}, 32'h41);
        step();
        check_eq("echo_cnt0", {28'd0, fifo_count}, 32'h0);

        // Burst of 9 with TX blocked: FIFO saturates, ninth byte stays pending
        tbr = 1'b0;
        for (int i = 0; i < 9; i++) push_rx(8'h30 + 8'(i));
        wait_count(8, 60, "burst_fill");
        begin
            int rd_seen;
            rd_seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (iocs && iorw) rd_seen = rd_seen + 1;
            end
            check_eq("burst_no_rd_full", rd_seen, 0);
        end
        check_eq("burst_hold_cnt", {28'd0, fifo_count}, 32'h8);
        check_eq("burst_rda_pend", {31'd0, rda}, 32'h1);
        base = tx_cnt;
        tbr = 1'b1;
        wait_tx(base + 9, 100, "burst_drain");
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("burst_byte%0d", i), {24'd0, tx_log[base + i]}, 32'h30 + i);
        check_eq("burst_empty", {28'd0, fifo_count}, 32'h0);

        // Reprogram from IDLE back to 9600
        tbr = 1'b0;
        br_cfg = 2'b01;
        check_div("re9600", 8'h44, 8'h01);

        // Alternation with a mid-stream br_cfg change to 19200 (161 = 0x00A1)
        for (int i = 0; i < 6; i++) push_rx(8'h50 + 8'(i));
        wait_count(2, 20, "alt_fill");
        base = tx_cnt;
        tbr = 1'b1;
        step();
        check_eq("alt_wr_first", {31'd0, iorw}, 32'h0);
        check_eq("alt_wr_dat", {24'd0, databus}, 32'h50);
        br_cfg = 2'b10;
        step();
        check_eq("alt_wr_done_cs", {31'd0, iocs}, 32'h0);
        check_eq("alt_wr_done_cnt", {28'd0, fifo_count}, 32'h1);
        step();
        check_eq("alt_cfg_lo_addr", {30'd0, ioaddr}, 32'h2);
        check_eq("alt_cfg_lo_dat", {24'd0, databus}, 32'hA1);
        check_eq("alt_cfg_undone", {31'd0, cfg_done}, 32'h0);
        step();
        check_eq("alt_cfg_hi_addr", {30'd0, ioaddr}, 32'h3);
        check_eq("alt_cfg_hi_dat", {24'd0, databus}, 32'h00);
        step();
        check_eq("alt_cfg_done", {31'd0, cfg_done}, 32'h1);
        check_eq("alt_fifo_kept", {28'd0, fifo_count}, 32'h1);
        step();
        check_eq("alt_rd_cs", {31'd0, iocs}, 32'h1);
        check_eq("alt_rd_rw", {31'd0, iorw}, 32'h1);
        step();
        check_eq("alt_rd_cnt", {28'd0, fifo_count}, 32'h2);
        step();
        check_eq("alt_wr2_rw", {31'd0, iorw}, 32'h0);
        check_eq("alt_wr2_dat", {24'd0, databus}, 32'h51);
        step();
        step();
        check_eq("alt_rd2_rw", {31'd0, iorw & iocs}, 32'h1);
        wait_tx(base + 6, 80, "alt_drain");
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("alt_byte%0d", i), {24'd0, tx_log[base + i]}, 32'h50 + i);
        check_eq("alt_empty", {28'd0, fifo_count}, 32'h0);

        // Reset landing on a WR cycle with two bytes stored
        tbr = 1'b0;
        push_rx(8'h20);
        push_rx(8'h21);
        wait_count(2, 20, "rstwr_fill");
        tbr = 1'b1;
        step();
        check_eq("rstwr_in_wr", {31'd0, iocs & ~iorw}, 32'h1);
        rst = 1'b1;
        step();
        check_eq("rstwr_iocs", {31'd0, iocs}, 32'h0);
        check_eq("rstwr_iorw", {31'd0, iorw}, 32'h1);
        check_eq("rstwr_count", {28'd0, fifo_count}, 32'h0);
        check_eq("rstwr_cfg_done", {31'd0, cfg_done}, 32'h0);
        rst = 1'b0;
        check_div("rst19200", 8'hA1, 8'h00);

        // Case folding at and around the lower-case range
`ifdef SPART_DRV_UPCASE_EN
        up_exp[0] = 8'h41; up_exp[1] = 8'h7B; up_exp[2] = 8'h60; up_exp[3] = 8'h5A;
`else
        up_exp[0] = 8'h61; up_exp[1] = 8'h7B; up_exp[2] = 8'h60; up_exp[3] = 8'h7A;
`endif
        base = tx_cnt;
        push_rx(8'h61);
        push_rx(8'h7B);
        push_rx(8'h60);
        push_rx(8'h7A);
        wait_tx(base + 4, 60, "case_drain");
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("case_byte%0d", i), {24'd0, tx_log[base + i]}, {24'd0, up_exp[i]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
